// File: rtl/ram_ctrl.sv
// Single-port word RAM with a valid/ready request channel and a registered read response.
// The array is zeroed by an INIT sweep after reset and on every clr pulse seen in RUN.
module ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_range  = {1'b0, req_addr} < DEPTH_W;
  assign req_idx   = req_addr[IDX_W-1:0];
  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = req_wdata;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_INIT: begin
        // The sweep owns the write port; clr is ignored so the sweep is never restarted.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept && req_we && in_range) begin
          mem_we = 1'b1;
        end
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase

    // Response register: a pending response survives entry into INIT until consumed.
    if (accept && !req_we) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range;
      rsp_rdata_d = in_range ? mem[req_idx] : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl (DATA_W=8, DEPTH=16, ADDR_W=5): vector table plus
// hand sequences for stall, clear and reset corner cases.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       init_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ram_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request presented for a single edge with the consumer ready.
  task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'b1;
    #1;
    chk($sformatf("req_ready_addr%0d", a), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    $display("txn %s addr=%0d wdata=0x%02h -> rsp_valid=%0b rdata=0x%02h err=%0b",
             we ? "WR" : "RD", a, d, rsp_valid, rsp_rdata, rsp_err);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 100);
    chk(name, 32'(n), 32'd16);
  endtask

  vec_t vecs[12];
  logic [7:0] stream_exp[4];

  initial begin
    vecs[0]  = '{1'b1, 5'd3,  8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 5'd3,  8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 5'd20, 8'h11, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 5'd20, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 5'd4,  8'h00, 1'b1, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 5'd15, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 5'd15, 8'h00, 1'b1, 8'h3C, 1'b0};
    vecs[7]  = '{1'b1, 5'd0,  8'h7E, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  8'h00, 1'b1, 8'h7E, 1'b0};
    vecs[9]  = '{1'b0, 5'd31, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 5'd16, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 5'd3,  8'h00, 1'b1, 8'hA5, 1'b0};
    stream_exp[0] = 8'h7E;
    stream_exp[1] = 8'h00;
    stream_exp[2] = 8'h00;
    stream_exp[3] = 8'hA5;

    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("init_len_after_reset");

    for (int a = 0; a < 16; a++) begin
      do_req(1'b0, 5'(a), 8'h00);
      chk($sformatf("zero_valid_%0d", a), 32'(rsp_valid), 32'd1);
      chk($sformatf("zero_rdata_%0d", a), 32'(rsp_rdata), 32'd0);
      chk($sformatf("zero_err_%0d", a),   32'(rsp_err),   32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
        chk($sformatf("vec%0d_err", i),   32'(rsp_err),   32'(vecs[i].exp_err));
      end
    end

    // Write then read the same word on the very next edge
    do_req(1'b1, 5'd7, 8'h5A);
    chk("b2b_wr_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 5'd7, 8'h00);
    chk("b2b_rd_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rd_rdata", 32'(rsp_rdata), 32'h5A);

    // Stalled response, then a streaming burst
    do_req(1'b0, 5'd3, 8'h00);
    chk("stall_first_rdata", 32'(rsp_rdata), 32'hA5);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0; rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d_rdata", c), 32'(rsp_rdata), 32'hA5);
      $display("txn STALL cycle=%0d rsp_valid=%0b rdata=0x%02h", c, rsp_valid, rsp_rdata);
    end
    for (int a = 0; a < 4; a++) begin
      req_addr  = 5'(a);
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d_req_ready", a), 32'(req_ready), 32'd1);
      tick();
      chk($sformatf("stream%0d_valid", a), 32'(rsp_valid), 32'd1);
      chk($sformatf("stream%0d_rdata", a), 32'(rsp_rdata), 32'(stream_exp[a]));
      $display("txn STREAM addr=%0d rdata=0x%02h", a, rsp_rdata);
    end
    req_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 32'(rsp_valid), 32'd0);

    // Fill with 0xFF, then clear with a read accepted on the clr edge
    for (int a = 0; a < 16; a++) do_req(1'b1, 5'(a), 8'hFF);
    clr = 1'b1;
    do_req(1'b0, 5'd5, 8'h00);
    clr = 1'b0;
    rsp_ready = 1'b0;
    chk("clr_edge_valid", 32'(rsp_valid), 32'd1);
    chk("clr_edge_rdata", 32'(rsp_rdata), 32'hFF);
    chk("clr_edge_busy",  32'(init_busy), 32'd1);
    begin
      int n = 0;
      while (init_busy && n < 100) begin
        clr       = (n == 4);
        rsp_ready = (n >= 2);
        #1;
        if (n == 0) chk("clr_init_req_ready", 32'(req_ready), 32'd0);
        tick();
        n++;
        if (n == 2) begin
          chk("clr_pending_valid", 32'(rsp_valid), 32'd1);
          chk("clr_pending_rdata", 32'(rsp_rdata), 32'hFF);
        end
        if (n == 3) chk("clr_pending_consumed", 32'(rsp_valid), 32'd0);
      end
      clr = 1'b0;
      chk("clr_init_len", 32'(n), 32'd16);
      $display("txn CLR init_cycles=%0d", n);
    end
    for (int a = 0; a < 16; a++) begin
      do_req(1'b0, 5'(a), 8'h00);
      chk($sformatf("clr_zero_rdata_%0d", a), 32'(rsp_rdata), 32'd0);
    end

    // Reset with a pending response, then again mid-INIT
    do_req(1'b0, 5'd7, 8'h00);
    rsp_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy",  32'(init_busy), 32'd1);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_init_busy", 32'(init_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("init_len_after_mid_rst");
    do_req(1'b0, 5'd3, 8'h00);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of words; legal range 2..2**ADDR_W.
REQ-003 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 clr  input  1  SHALL request a re-zero of the whole array (level sampled on posedge clk).
REQ-007 req_valid  input  1  SHALL indicate a request is presented.
REQ-008 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-009 req_we  input  1  SHALL select write (1) or read (0).
REQ-010 req_addr  input  ADDR_W  SHALL be the word address.
REQ-011 req_wdata  input  DATA_W  SHALL be the write data.
REQ-012 rsp_valid  output  1  SHALL indicate read data is presented.
REQ-013 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-014 rsp_rdata  output  DATA_W  SHALL be the read data.
REQ-015 rsp_err  output  1  SHALL flag that the read address was >= DEPTH.
REQ-016 init_busy  output  1  SHALL be high while the array is being zeroed.

Function
REQ-017 FSM SHALL have two states: INIT (zeroing) and RUN.
REQ-018 In INIT, the block SHALL write zero to word cnt each cycle, cnt counting 0..DEPTH-1, then enter RUN the cycle after writing DEPTH-1; INIT lasts exactly DEPTH cycles.
REQ-019 init_busy SHALL equal (state==INIT); req_ready SHALL be 0 in INIT.
REQ-020 In RUN, req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally.
REQ-021 A request SHALL be accepted only on a posedge where req_valid && req_ready.
REQ-022 Accepted write with req_addr < DEPTH: word SHALL update at that edge; no response generated.
REQ-023 Accepted write with req_addr >= DEPTH: SHALL be discarded silently, no response.
REQ-024 Accepted read: rsp_valid SHALL rise on the same edge (1-cycle latency), with rsp_rdata = word at req_addr as of before that edge.
REQ-025 Accepted read with req_addr >= DEPTH: rsp_rdata SHALL be 0 and rsp_err 1; otherwise rsp_err 0.
REQ-026 Read the cycle after a write to the same address SHALL return the newly written data.
REQ-027 While rsp_valid && !rsp_ready, rsp_rdata and rsp_err SHALL stay stable and no request is accepted.
REQ-028 rsp_valid SHALL clear on rsp_ready unless a new read is accepted on the same edge (back-to-back reads, one per cycle, when rsp_ready held high).
REQ-029 clr sampled high in RUN SHALL move FSM to INIT with cnt=0 at that edge; a request accepted on that same edge SHALL complete normally (a write is then overwritten by the clear).
REQ-030 clr sampled high in INIT SHALL be ignored (cnt not restarted).
REQ-031 A response pending when INIT is entered via clr SHALL remain held until rsp_ready.
REQ-032 Array contents SHALL not be addressed by rst_n directly; zeroing is solely by INIT.

Reset
REQ-033 rst_n low SHALL immediately force: state INIT, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1, req_ready 0.
REQ-034 Reset asserted mid-INIT or with a pending response SHALL abort them; pending response lost; INIT restarts from 0 after release.

Verification (DATA_W=8, DEPTH=16, ADDR_W=5)
REQ-035 Release rst_n -> init_busy high exactly 16 cycles, then req_ready=1; read of every address 0..15 returns 0x00, rsp_err 0.
REQ-036 Write 0xA5 to addr 3, read addr 3 next cycle -> rsp_valid one cycle after acceptance with rsp_rdata 0xA5.
REQ-037 Write 0x11 to addr 20, read addr 20 -> rsp_rdata 0x00, rsp_err 1; addr 4 (20 mod 16) still reads 0x00.
REQ-038 Read addr 3 with rsp_ready low 5 cycles -> rsp_valid and 0xA5 held, req_ready 0 throughout; on rsp_ready high, back-to-back reads of addrs 0..3 stream one per cycle.
REQ-039 Pulse clr in RUN after writing 0xFF to addrs 0..15 -> init_busy high 16 cycles, all words then read 0x00; second clr pulse mid-INIT does not extend INIT.
REQ-040 Assert rst_n low with rsp_valid=1 and during INIT -> rsp_valid drops asynchronously, INIT restarts full 16 cycles after release.
